// File: rtl/crossgrid_pkg.sv
// Shared encodings for the crossgrid configuration controller: command ops,
// response status codes and controller FSM states.
package crossgrid_pkg;

    typedef enum logic [1:0] {
        OP_CONNECT    = 2'd0,
        OP_DISCONNECT = 2'd1,
        OP_QUERY      = 2'd2,
        OP_CLEAR_ALL  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_CONFLICT = 2'd1,
        ST_BAD_PORT = 2'd2,
        ST_NOT_CONN = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/crossgrid_route_table.sv
// Per-output routing table ({valid, src} per dst) with lookup by dst and a
// registered crosspoint decode that lands in the same cycle as the table write.
module crossgrid_route_table
    import crossgrid_pkg::*;
#(
    parameter int number_ports = 4,
    localparam int PW = $clog2(number_ports)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [PW-1:0]                    wr_dst,
    input  logic [PW-1:0]                    wr_src,
    input  logic                             clr_en,
    input  logic [PW-1:0]                    clr_dst,
    input  logic                             clr_all,
    input  logic [PW-1:0]                    lk_dst,
    output logic                             lk_valid,
    output logic [PW-1:0]                    lk_src,
    output logic                             any_valid,
    output logic [number_ports*number_ports-1:0] ctr
);

    localparam logic [PW:0] NP = (PW+1)'(number_ports);

    logic [number_ports-1:0]         tbl_v, tbl_v_n;
    logic [number_ports-1:0][PW-1:0] tbl_s, tbl_s_n;
    logic [number_ports*number_ports-1:0] ctr_n;

    always_comb begin
        tbl_v_n = tbl_v;
        tbl_s_n = tbl_s;
        if (clr_all)
            tbl_v_n = '0;
        if (clr_en && ({1'b0, clr_dst} < NP))
            tbl_v_n[clr_dst] = 1'b0;
        if (wr_en && ({1'b0, wr_dst} < NP)) begin
            tbl_v_n[wr_dst] = 1'b1;
            tbl_s_n[wr_dst] = wr_src;
        end
    end

    // Decode from the next-state table so ctr moves on the same edge as the write.
    always_comb begin
        ctr_n = '0;
        for (int unsigned j = 0; j < number_ports; j++)
            for (int unsigned i = 0; i < number_ports; i++)
                if (tbl_v_n[j] && (tbl_s_n[j] == i[PW-1:0]))
                    ctr_n[i*number_ports + j] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_v <= '0;
            tbl_s <= '0;
            ctr   <= '0;
        end else begin
            tbl_v <= tbl_v_n;
            tbl_s <= tbl_s_n;
            ctr   <= ctr_n;
        end
    end

    always_comb begin
        lk_valid = 1'b0;
        lk_src   = '0;
        if ({1'b0, lk_dst} < NP) begin
            lk_valid = tbl_v[lk_dst];
            lk_src   = tbl_s[lk_dst];
        end
    end

    assign any_valid = |tbl_v;

endmodule

// File: rtl/crossgrid_ctrl.sv
// Command/response controller for the crossgrid fabric: validates commands
// against the routing table, updates ctr and holds cfg_stable low while it settles.
module crossgrid_ctrl
    import crossgrid_pkg::*;
#(
    parameter int number_ports  = 4,
    parameter int settle_cycles = 2,
    localparam int PW = $clog2(number_ports)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [1:0]                           cmd_op,
    input  logic [PW-1:0]                        cmd_src,
    input  logic [PW-1:0]                        cmd_dst,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [1:0]                           rsp_status,
    output logic [PW-1:0]                        rsp_src,
    output logic [number_ports*number_ports-1:0] ctr,
    output logic                                 cfg_stable
);

    localparam logic [PW:0] NP = (PW+1)'(number_ports);
    localparam int CW = (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);

    state_t        state;
    op_t           op_q;
    logic [PW-1:0] src_q, dst_q;
    logic [CW-1:0] cnt;

    logic          lk_valid, any_valid;
    logic [PW-1:0] lk_src;

    status_t       ev_status;
    logic [PW-1:0] ev_src;
    logic          ev_change, ev_wr, ev_clr, ev_clr_all;
    logic          bad_src, bad_dst, in_check;

    assign bad_src  = ({1'b0, src_q} >= NP);
    assign bad_dst  = ({1'b0, dst_q} >= NP);
    assign in_check = (state == S_CHECK);

    always_comb begin
        ev_status  = ST_OK;
        ev_src     = src_q;
        ev_change  = 1'b0;
        ev_wr      = 1'b0;
        ev_clr     = 1'b0;
        ev_clr_all = 1'b0;
        case (op_q)
            OP_CONNECT: begin
                if (bad_src || bad_dst) begin
                    ev_status = ST_BAD_PORT;
                end else if (!lk_valid) begin
                    ev_wr     = 1'b1;
                    ev_change = 1'b1;
                end else if (lk_src != src_q) begin
                    ev_status = ST_CONFLICT;
                    ev_src    = lk_src;
                end
            end
            OP_DISCONNECT: begin
                if (bad_src || bad_dst) begin
                    ev_status = ST_BAD_PORT;
                end else if (lk_valid && (lk_src == src_q)) begin
                    ev_clr    = 1'b1;
                    ev_change = 1'b1;
                end else begin
                    ev_status = ST_NOT_CONN;
                end
            end
            OP_QUERY: begin
                if (bad_dst) begin
                    ev_status = ST_BAD_PORT;
                end else if (lk_valid) begin
                    ev_src = lk_src;
                end else begin
                    ev_status = ST_NOT_CONN;
                    ev_src    = '0;
                end
            end
            default: begin
                ev_clr_all = any_valid;
                ev_change  = any_valid;
            end
        endcase
    end

    crossgrid_route_table #(
        .number_ports (number_ports)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (in_check && ev_wr),
        .wr_dst    (dst_q),
        .wr_src    (src_q),
        .clr_en    (in_check && ev_clr),
        .clr_dst   (dst_q),
        .clr_all   (in_check && ev_clr_all),
        .lk_dst    (dst_q),
        .lk_valid  (lk_valid),
        .lk_src    (lk_src),
        .any_valid (any_valid),
        .ctr       (ctr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_src    <= '0;
            cfg_stable <= 1'b1;
            cnt        <= '0;
            op_q       <= OP_CONNECT;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        src_q     <= cmd_src;
                        dst_q     <= cmd_dst;
                        cmd_ready <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    rsp_status <= ev_status;
                    rsp_src    <= ev_src;
                    if (ev_change) begin
                        cfg_stable <= 1'b0;
                        cnt        <= CW'(settle_cycles);
                        state      <= S_SETTLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        cfg_stable <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crossgrid_ctrl.sv
// Bench for crossgrid_ctrl: directed scenarios plus randomized commands on an
// N=4 and an N=3 instance, checked against a per-dst driver-array model.
module tb_crossgrid_ctrl;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [1:0] cmd_src = '0;
    logic [1:0] cmd_dst = '0;
    logic cv4 = 1'b0, cv3 = 1'b0, rr4 = 1'b0, rr3 = 1'b0;

    logic        cr4, rv4, cs4, cr3, rv3, cs3;
    logic [1:0]  st4, st3, rs4, rs3;
    logic [15:0] ctr4;
    logic [8:0]  ctr3;

    int checks = 0;
    int errors = 0;

    // model: drv[s][dst] = driving src, or -1 when the output is free
    int drv [2][4];
    int nports [2] = '{4, 3};

    always #5 clk = ~clk;

    crossgrid_ctrl #(.number_ports(4), .settle_cycles(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv4), .cmd_ready(cr4), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .rsp_valid(rv4), .rsp_ready(rr4),
        .rsp_status(st4), .rsp_src(rs4), .ctr(ctr4), .cfg_stable(cs4));

    crossgrid_ctrl #(.number_ports(3), .settle_cycles(SETTLE)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv3), .cmd_ready(cr3), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_status(st3), .rsp_src(rs3), .ctr(ctr3), .cfg_stable(cs3));

    function automatic logic [15:0] get_ctr(input int s);
        return (s == 0) ? ctr4 : {7'b0, ctr3};
    endfunction
    function automatic logic get_rv(input int s);
        return (s == 0) ? rv4 : rv3;
    endfunction
    function automatic logic get_rdy(input int s);
        return (s == 0) ? cr4 : cr3;
    endfunction
    function automatic logic get_stable(input int s);
        return (s == 0) ? cs4 : cs3;
    endfunction
    function automatic int get_st(input int s);
        return (s == 0) ? int'(st4) : int'(st3);
    endfunction
    function automatic int get_rsrc(input int s);
        return (s == 0) ? int'(rs4) : int'(rs3);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 4; d++)
                drv[s][d] = -1;
    endfunction

    task automatic model_apply(input int s, input int op, input int src, input int dst,
                               output int st, output int rs, output int chg);
        int n;
        n = nports[s];
        st = 0; rs = src; chg = 0;
        case (op)
            0: if (src >= n || dst >= n) st = 2;
               else if (drv[s][dst] < 0) begin drv[s][dst] = src; chg = 1; end
               else if (drv[s][dst] != src) begin st = 1; rs = drv[s][dst]; end
            1: if (src >= n || dst >= n) st = 2;
               else if (drv[s][dst] == src) begin drv[s][dst] = -1; chg = 1; end
               else st = 3;
            2: if (dst >= n) st = 2;
               else if (drv[s][dst] >= 0) rs = drv[s][dst];
               else begin st = 3; rs = 0; end
            default: for (int d = 0; d < n; d++) begin
                if (drv[s][d] >= 0) chg = 1;
                drv[s][d] = -1;
            end
        endcase
    endtask

    function automatic logic [15:0] model_ctr(input int s);
        logic [15:0] v;
        int n;
        n = nports[s];
        v = '0;
        for (int j = 0; j < n; j++)
            if (drv[s][j] >= 0) v[drv[s][j]*n + j] = 1'b1;
        return v;
    endfunction

    // Drives one command, records timing/response, holds rsp_ready low for
    // 'hold' cycles while poking cmd_valid, then completes the handshake.
    task automatic send_cmd(input int s, input int op, input int src, input int dst, input int hold,
                            output int lat, output int st, output int rs, output logic [15:0] ctr1,
                            output int low, output bit hold_ok, output bit rdy_after);
        lat = -1; st = -1; rs = -1; ctr1 = '0; low = 0; hold_ok = 1'b1; rdy_after = 1'b0;
        @(negedge clk);
        cmd_op = 2'(op); cmd_src = 2'(src); cmd_dst = 2'(dst);
        if (s == 0) cv4 = 1'b1; else cv3 = 1'b1;
        @(posedge clk); #1;
        cv4 = 1'b0; cv3 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) ctr1 = get_ctr(s);
            if (!get_stable(s)) low++;
            if (get_rv(s)) begin lat = k; break; end
        end
        if (lat < 0) return;
        st = get_st(s); rs = get_rsrc(s);
        for (int h = 0; h < hold; h++) begin
            cmd_op = 2'($urandom); cmd_src = 2'($urandom); cmd_dst = 2'($urandom);
            if (s == 0) cv4 = 1'b1; else cv3 = 1'b1;
            @(posedge clk); #1;
            cv4 = 1'b0; cv3 = 1'b0;
            if (!get_rv(s) || get_st(s) != st || get_rsrc(s) != rs || get_rdy(s)) hold_ok = 1'b0;
        end
        if (s == 0) rr4 = 1'b1; else rr3 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0; rr3 = 1'b0;
        rdy_after = get_rdy(s) && !get_rv(s);
    endtask

    task automatic test_reset();
        checks++; if (ctr4 !== 16'h0) begin errors++; $display("FAIL reset_ctr got %h want 0000", ctr4); end
        checks++; if ({cr4, cs4, rv4} !== 3'b110) begin errors++; $display("FAIL reset_flags ready/stable/valid got %b want 110", {cr4, cs4, rv4}); end
        checks++; if ({st4, rs4} !== 4'b0) begin errors++; $display("FAIL reset_rsp status/src got %b want 0000", {st4, rs4}); end
    endtask

    task automatic test_reset_mid_settle();
        bit stray;
        @(negedge clk);
        cmd_op = 2'd0; cmd_src = 2'd1; cmd_dst = 2'd0; cv4 = 1'b1;
        @(posedge clk); #1; cv4 = 1'b0;
        @(posedge clk); #1;
        checks++; if ({cs4, ctr4} !== {1'b0, 16'h0010}) begin errors++; $display("FAIL mid_settle_pre stable/ctr got %b/%h want 0/0010", cs4, ctr4); end
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if ({ctr4, cr4, cs4, rv4, st4, rs4} !== {16'h0, 3'b110, 4'b0}) begin
            errors++; $display("FAIL mid_settle_reset ctr=%h ready=%b stable=%b valid=%b st=%0d src=%0d want 0000/1/1/0/0/0", ctr4, cr4, cs4, rv4, st4, rs4); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rv4 || !cr4 || !cs4 || ctr4 != 16'h0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL mid_settle_stray got activity=%b want 0", stray); end
    endtask

    task automatic test_connect();
        int lat, st, rs, low, est, ers, chg; logic [15:0] c1; bit hok, rdy;
        send_cmd(0, 0, 2, 1, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 0, 2, 1, est, ers, chg);
        checks++; if (c1 !== 16'h0200) begin errors++; $display("FAIL connect_ctr got %h want 0200", c1); end
        checks++; if (low !== SETTLE + 1) begin errors++; $display("FAIL connect_stable_low got %0d want %0d", low, SETTLE + 1); end
        checks++; if (lat !== SETTLE + 2) begin errors++; $display("FAIL connect_latency got %0d want %0d", lat, SETTLE + 2); end
        checks++; if ({st, rs} !== {32'd0, 32'd2}) begin errors++; $display("FAIL connect_rsp got st=%0d src=%0d want 0/2", st, rs); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL connect_ready_after got %b want 1", rdy); end
    endtask

    task automatic test_conflict();
        int lat, st, rs, low, est, ers, chg; logic [15:0] c1; bit hok, rdy;
        send_cmd(0, 0, 0, 1, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 0, 0, 1, est, ers, chg);
        checks++; if ({lat, st, rs} !== {32'd1, 32'd1, 32'd2}) begin errors++; $display("FAIL conflict_rsp got lat=%0d st=%0d src=%0d want 1/1/2", lat, st, rs); end
        checks++; if ({c1, low} !== {16'h0200, 32'd0}) begin errors++; $display("FAIL conflict_ctr got ctr=%h low=%0d want 0200/0", c1, low); end
    endtask

    task automatic test_fanout();
        int lat, st, rs, low, est, ers, chg; logic [15:0] c1; bit hok, rdy;
        send_cmd(0, 0, 2, 3, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 0, 2, 3, est, ers, chg);
        checks++; if ({c1, st, lat} !== {16'h0A00, 32'd0, 32'd4}) begin errors++; $display("FAIL fanout_connect got ctr=%h st=%0d lat=%0d want 0a00/0/4", c1, st, lat); end
        send_cmd(0, 2, 0, 3, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 2, 0, 3, est, ers, chg);
        checks++; if ({lat, st, rs} !== {32'd1, 32'd0, 32'd2}) begin errors++; $display("FAIL fanout_query got lat=%0d st=%0d src=%0d want 1/0/2", lat, st, rs); end
        send_cmd(0, 1, 1, 3, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 1, 1, 3, est, ers, chg);
        checks++; if ({lat, st, c1} !== {32'd1, 32'd3, 16'h0A00}) begin errors++; $display("FAIL fanout_disc_other got lat=%0d st=%0d ctr=%h want 1/3/0a00", lat, st, c1); end
        send_cmd(0, 0, 2, 3, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 0, 2, 3, est, ers, chg);
        checks++; if ({lat, st, low} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL fanout_reconnect got lat=%0d st=%0d low=%0d want 1/0/0", lat, st, low); end
    endtask

    task automatic test_bad_port();
        int lat, st, rs, low, est, ers, chg; logic [15:0] c1; bit hok, rdy;
        send_cmd(1, 0, 0, 3, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(1, 0, 0, 3, est, ers, chg);
        checks++; if ({lat, st, rs, c1} !== {32'd1, 32'd2, 32'd0, 16'h0}) begin errors++; $display("FAIL badport_n3 got lat=%0d st=%0d src=%0d ctr=%h want 1/2/0/0000", lat, st, rs, c1); end
        send_cmd(1, 3, 0, 0, 0, lat, st, rs, c1, low, hok, rdy);
        model_apply(1, 3, 0, 0, est, ers, chg);
        checks++; if ({lat, st, low} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL clear_empty got lat=%0d st=%0d low=%0d want 1/0/0", lat, st, low); end
    endtask

    task automatic test_hold();
        int lat, st, rs, low, est, ers, chg; logic [15:0] c1; bit hok, rdy;
        send_cmd(0, 3, 1, 0, 5, lat, st, rs, c1, low, hok, rdy);
        model_apply(0, 3, 1, 0, est, ers, chg);
        checks++; if ({c1, st, lat} !== {16'h0, 32'd0, 32'd4}) begin errors++; $display("FAIL hold_clear got ctr=%h st=%0d lat=%0d want 0000/0/4", c1, st, lat); end
        checks++; if ({hok, rdy} !== 2'b11) begin errors++; $display("FAIL hold_stable_ready got hold_ok=%b ready_after=%b want 11", hok, rdy); end
        checks++; if (ctr4 !== 16'h0) begin errors++; $display("FAIL hold_ignored_cmds got ctr=%h want 0000", ctr4); end
    endtask

    task automatic test_random();
        int lat, st, rs, low, est, ers, chg, s, op, src, dst, hold; logic [15:0] c1, ec; bit hok, rdy;
        for (int it = 0; it < 80; it++) begin
            s    = ($urandom_range(0, 3) == 0) ? 1 : 0;
            op   = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 3));
            if (op == 3 && $urandom_range(0, 2) != 0) op = 0;
            src  = int'($urandom_range(0, 3));
            dst  = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            send_cmd(s, op, src, dst, hold, lat, st, rs, c1, low, hok, rdy);
            model_apply(s, op, src, dst, est, ers, chg);
            ec = model_ctr(s);
            checks++; if ({st, rs} !== {est, ers}) begin errors++; $display("FAIL rand_rsp it=%0d dut=%0d op=%0d got st=%0d src=%0d want %0d/%0d", it, s, op, st, rs, est, ers); end
            checks++; if (lat !== (chg ? SETTLE + 2 : 1)) begin errors++; $display("FAIL rand_latency it=%0d got %0d want %0d", it, lat, chg ? SETTLE + 2 : 1); end
            checks++; if (c1 !== ec) begin errors++; $display("FAIL rand_ctr it=%0d got %h want %h", it, c1, ec); end
            checks++; if (low !== (chg ? SETTLE + 1 : 0)) begin errors++; $display("FAIL rand_stable_low it=%0d got %0d want %0d", it, low, chg ? SETTLE + 1 : 0); end
            checks++; if ({hok, rdy} !== 2'b11) begin errors++; $display("FAIL rand_handshake it=%0d got hold_ok=%b ready_after=%b want 11", it, hok, rdy); end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_reset_mid_settle();
        test_connect();
        test_conflict();
        test_fanout();
        test_bad_port();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
